// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: fetch exception codes, the nop encoding and the
// per-entry record carried from fetch to decode.
package cpu_pkg;

    localparam logic [4:0]  EXC_NONE  = 5'd0;
    localparam logic [4:0]  EXC_ADEL  = 5'd4;
    localparam logic [31:0] INSTR_NOP = 32'h0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  exc;
        logic        bd;
    } fetch_entry_t;

    // An excepting fetch must never reach decode as a real opcode.
    function automatic logic [31:0] decode_instr(input fetch_entry_t e);
        return (e.exc != EXC_NONE) ? INSTR_NOP : e.instr;
    endfunction

endpackage

// File: rtl/fetch_buffer_mem.sv
// DEPTH x fetch_entry_t register array: one synchronous write port, one
// asynchronous read port. Contents are deliberately not reset.
module fetch_buffer_mem
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [PTR_W-1:0]   waddr,
    input  fetch_entry_t       wdata,
    input  logic [PTR_W-1:0]   raddr,
    output fetch_entry_t       rdata
);

    fetch_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_buffer.sv
// Fetch-to-decode instruction queue with single-edge redirect flush.
// Optional zero-latency empty-queue bypass: define FETCH_BUF_BYPASS_EN.
module fetch_buffer
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             f_valid,
    output logic             f_ready,
    input  logic [31:0]      f_pc,
    input  logic [31:0]      f_instr,
    input  logic [4:0]       f_exc,
    input  logic             f_bd,
    output logic             d_valid,
    input  logic             d_ready,
    output logic [31:0]      d_pc,
    output logic [31:0]      d_instr,
    output logic [4:0]       d_exc,
    output logic             d_bd,
    input  logic             flush,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   cnt;

    logic         q_valid;
    logic         push;
    logic         pop;
    fetch_entry_t f_entry;
    fetch_entry_t rd_entry;
    fetch_entry_t head;

    assign f_entry = '{pc: f_pc, instr: f_instr, exc: f_exc, bd: f_bd};
    assign q_valid = (cnt != '0);
    assign f_ready = (cnt != FULL_CNT);
    assign pop     = q_valid & d_ready & ~flush;

`ifdef FETCH_BUF_BYPASS_EN
    logic bypass;

    // Empty queue: present the fetch entry directly; if decode takes it, skip the write.
    assign bypass  = ~q_valid & f_valid & ~flush;
    assign d_valid = q_valid | bypass;
    assign head    = q_valid ? rd_entry : f_entry;
    assign push    = f_valid & f_ready & ~flush & ~(bypass & d_ready);
`else
    assign d_valid = q_valid;
    assign head    = rd_entry;
    assign push    = f_valid & f_ready & ~flush;
`endif

    fetch_buffer_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (f_entry),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    always_comb begin
        d_pc    = 32'h0;
        d_instr = INSTR_NOP;
        d_exc   = EXC_NONE;
        d_bd    = 1'b0;
        if (d_valid) begin
            d_pc    = head.pc;
            d_instr = decode_instr(head);
            d_exc   = head.exc;
            d_bd    = head.bd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign count = cnt;

endmodule
